lsu_byte_sequencer: RTL and testbench
=====================================

# lsu_byte_sequencer

Load/store sequencer between the core's MEM stage and the byte-wide 16K data RAM. It accepts one 32-bit load or store request at a time and performs 1, 2 or 4 back-to-back single-byte RAM accesses in little-endian order. For loads it assembles the returned bytes and applies sign or zero extension. It stalls the pipeline through a valid/ready handshake while an access is in progress.

## Interface
Parameters:
- ADDR_W, default 14: RAM address width; the RAM depth is 2^ADDR_W bytes.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  sequencer can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned_i  in  1  zero-extend loads (lbu/lhu); ignored for word loads and for stores.
- req_addr_i  in  32  byte address; only [ADDR_W-1:0] is used.
- req_wdata_i  in  32  store data; byte k goes to address addr+k.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores.
- rsp_err_o  out  1  misalignment error; only driven when LSU_MISALIGN_CHECK_EN is defined, else tied 0.
- ram_wren_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  8  RAM write byte.
- ram_rdata_i  in  8  RAM read byte; combinational from ram_addr_o in the same cycle.

## Operation
- FSM states:
  - IDLE: req_ready_o=1. When req_valid_i=1, latch we, size, unsigned, addr[ADDR_W-1:0] and wdata, set idx=0 and last = 0, 1 or 3 according to size, then go to ACCESS.
  - ACCESS: drive ram_addr_o = base + idx, truncated to ADDR_W bits so it wraps modulo 2^ADDR_W.
    - Store: ram_wren_o=1 and ram_wdata_o = wdata[8*idx+:8].
    - Load: ram_wren_o=0, and on the clock edge capture ram_rdata_i into byte lane idx of the assembly register.
    - If idx==last, go to RESP; otherwise idx increments.
  - RESP: rsp_valid_o=1 for exactly one cycle, then go to IDLE. req_ready_o=0.
- Load extension:
  - Byte: bit 7 replicated into [31:8] when signed, zeros when unsigned.
  - Half: bit 15 replicated into [31:16] when signed, zeros when unsigned.
  - Word: no extension.
- rsp_rdata_o holds its value until the next RESP; it is 0 after any store RESP.
- Outside ACCESS: ram_wren_o=0, ram_addr_o=0, ram_wdata_o=0.
- Requests arriving in ACCESS or RESP are not accepted. The requester must hold req_* stable until req_ready_o=1 and a handshake occurs.
- Misaligned requests without the checker are performed byte-sequentially as described, including address wrap.

## Timing
- Accept edge is T0. ACCESS occupies cycles T1..T(n), where n = 1, 2 or 4 bytes. RESP is cycle T(n+1).
- Request-to-response latency: 2 cycles for byte, 3 for half, 5 for word. The next request can be accepted in the cycle after RESP.
- Throughput: one request per n+2 cycles.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_wren_o=0, ram_addr_o=0, ram_wdata_o=0.
- Reset asserted mid-ACCESS aborts immediately with all outputs at their reset values. Store bytes already written remain in the RAM, and no response is issued.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - In IDLE, a half request with addr[0]=1, or a word request with addr[1:0]!=0, is accepted and goes straight to RESP.
  - No RAM access occurs; ram_wren_o stays 0.
  - RESP drives rsp_err_o=1 and rsp_rdata_o=0. Latency is 1 cycle.
  - rsp_err_o=0 on every other response.
- LSU_MISALIGN_CHECK_EN undefined: rsp_err_o is tied to 0, and misaligned accesses are performed as byte sequences.

## Test plan
- Store word 0xDEADBEEF at 0x0100, then load word from 0x0100 -> RAM bytes 0x100..0x103 = EF BE AD DE; load rsp_rdata_o=0xDEADBEEF; RESP 5 cycles after accept.
- Store byte 0x80 at 0x0005, then lb 0x0005 -> 0xFFFFFF80, and lbu 0x0005 -> 0x00000080; each RESP 2 cycles after accept.
- Store half 0x8001 at 0x0010, then lh -> 0xFFFF8001, and lhu -> 0x00008001.
- Word store at 0x3FFE, macro undefined -> writes land at 0x3FFE, 0x3FFF, 0x0000, 0x0001; rsp_err_o=0.
- Macro defined, lw from 0x0002 -> RESP 1 cycle after accept with rsp_err_o=1, rsp_rdata_o=0, and no ram_wren_o pulse.
- Assert rst_ni low during the 3rd byte of a word store -> outputs take reset values immediately; no RESP; bytes 0 and 1 written, bytes 2 and 3 unchanged; req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response port between the core's MEM stage and lsu_byte_sequencer.
// The master modport is the core side; the slave modport is the sequencer side.
interface lsu_byte_sequencer_if;
  // Handshake: a request transfers on the rising edge where req_valid_i && req_ready_o.
  // The requester holds every req_* field stable until that edge. rsp_valid_o is a
  // one-cycle pulse with no back-pressure. rsp_rdata_o and rsp_err_o qualify it.
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_size_i,
    output req_unsigned_i,
    output req_addr_i,
    output req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  rsp_err_o
  );

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_size_i,
    input  req_unsigned_i,
    input  req_addr_i,
    input  req_wdata_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o,
    output rsp_err_o
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer between the MEM stage and a byte-wide RAM.
// Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lsu_byte_sequencer_if.slave bus,
  output logic              ram_wren_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic              ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wbyte_q;

  logic [1:0]        idx_inc;
  logic [1:0]        req_last;
  logic [31:0]       asm_next;
  logic [31:0]       load_ext;
  logic              trap;

  // Only the low ADDR_W address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr_i[31:ADDR_W];

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  assign trap = (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                (bus.req_size_i[1] && bus.req_addr_i[1:0] != 2'b00);
  assign bus.rsp_err_o = err_q;
`else
  assign trap = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  always_comb begin
    idx_inc = idx_q + 2'd1;
    case (bus.req_size_i)
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    // Byte arriving this cycle merged in, so the final lane needs no extra cycle.
    asm_next = asm_q;
    asm_next[{idx_q, 3'b000} +: 8] = ram_rdata_i;
    case (last_q)
      2'd0:    load_ext = uns_q ? {24'd0, asm_next[7:0]}
                                : {{24{asm_next[7]}}, asm_next[7:0]};
      2'd1:    load_ext = uns_q ? {16'd0, asm_next[15:0]}
                                : {{16{asm_next[15]}}, asm_next[15:0]};
      default: load_ext = asm_next;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wbyte_q     <= 8'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            uns_q   <= bus.req_unsigned_i;
            base_q  <= bus.req_addr_i[ADDR_W-1:0];
            wdata_q <= bus.req_wdata_i;
            idx_q   <= 2'd0;
            last_q  <= req_last;
            asm_q   <= 32'd0;
            ready_q <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= trap;
`endif
            if (trap) begin
              // Misaligned: respond with an error without touching the RAM.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= 32'd0;
            end else begin
              state_q <= ST_ACCESS;
              wren_q  <= bus.req_we_i;
              addr_q  <= bus.req_addr_i[ADDR_W-1:0];
              wbyte_q <= bus.req_we_i ? bus.req_wdata_i[7:0] : 8'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) asm_q <= asm_next;
          if (idx_q == last_q) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= we_q ? 32'd0 : load_ext;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wbyte_q     <= 8'd0;
          end else begin
            // Address arithmetic wraps modulo the RAM depth.
            idx_q   <= idx_inc;
            addr_q  <= base_q + ADDR_W'(idx_inc);
            wbyte_q <= we_q ? wdata_q[{idx_inc, 3'b000} +: 8] : 8'd0;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
          err_q       <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign ram_wren_o      = wren_q;
  assign ram_addr_o      = addr_q;
  assign ram_wdata_o     = wbyte_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Testbench for lsu_byte_sequencer: directed vector table, corner sequences and
// randomized traffic against a byte-array memory model.
module tb_lsu_byte_sequencer;
  localparam int          ADDR_W = 14;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [1:0]        dbg_state;
  logic              ram_clear;

  logic [7:0]  ram     [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  lsu_byte_sequencer_if bus();

  lsu_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .ram_wren_o  (ram_wren),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .dbg_state_o (dbg_state)
  );

  // Clock and RAM
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= 8'h00;
    end else if (ram_wren) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_trap(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    int n;
    n = nbytes(size);
    return (n > 1) && ((addr % 32'(n)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: little-endian byte array with arithmetic sign extension.
  task automatic model_apply(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int wr);
    int          n;
    int unsigned a;
    longint      v;
    n = nbytes(size);
    a = addr % DEPTH;
    v = 0;
    if (is_trap(size, addr)) begin
      rdata = 32'd0; err = 1'b1; lat = 1; wr = 0;
      return;
    end
    err = 1'b0;
    lat = n + 1;
    wr  = we ? n : 0;
    if (we) begin
      for (int k = 0; k < n; k++)
        ref_mem[(a + k) % DEPTH] = 8'((wdata >> (8 * k)) & 32'hFF);
      rdata = 32'd0;
    end else begin
      for (int k = 0; k < n; k++)
        v = v + (longint'(ref_mem[(a + k) % DEPTH]) << (8 * k));
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
      rdata = 32'(v);
    end
  endtask

  // Driver: issue one request, follow it to its response, check against the model.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] rd_out, output int lat_out);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          wr;
    int          w;
    bit          got;
    logic        er;
    model_apply(we, size, uns, addr, wdata, exp_rd, exp_err, exp_lat, exp_wr);
    exp_q.push_back(exp_rd);
    rd_out  = 32'hx;
    lat_out = 0;
    @(negedge clk);
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_valid_i    = 1'b1;
    w = 0;
    while (!bus.req_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, bus.req_ready_o, 1'b1);
    if (!bus.req_ready_o) begin
      bus.req_valid_i = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    got = 1'b0;
    wr  = 0;
    er  = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (ram_wren) wr++;
      if (bus.rsp_valid_o) begin
        got     = 1'b1;
        lat_out = j;
        rd_out  = bus.rsp_rdata_o;
        er      = bus.rsp_err_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " rsp_seen"}, got, 1'b1);
    if (got) begin
      check({tag, " rdata"}, rd_out, exp_q.pop_front());
      check({tag, " latency"}, lat_out, exp_lat);
      check({tag, " err"}, er, exp_err);
      check({tag, " wr_count"}, wr, exp_wr);
      @(posedge clk);
      #1;
      check({tag, " rsp_pulse"}, bus.rsp_valid_o, 1'b0);
      check({tag, " ready_after"}, bus.req_ready_o, 1'b1);
      check({tag, " rdata_hold"}, bus.rsp_rdata_o, exp_rd);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, bus.req_ready_o, 1'b1);
    check({tag, " rsp_valid"}, bus.rsp_valid_o, 1'b0);
    check({tag, " rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
    check({tag, " rsp_err"}, bus.rsp_err_o, 1'b0);
    check({tag, " ram_wren"}, ram_wren, 1'b0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_wdata"}, ram_wdata, 8'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    int          low;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 5};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_0080, 32'h0000_0000, 2};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0005, 32'h0,         32'hFFFF_FF80, 2};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0,         32'h0000_0080, 2};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_8001, 32'h0000_0000, 3};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_8001, 3};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_8001, 3};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[9]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         32'hFFFF_FFBE, 2};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 3};

    // Reset
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    ram_clear = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ram_clear = 1'b0;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              $sformatf("vec%0d", i), rd, lat);
      check($sformatf("vec%0d table_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d table_lat", i), lat, vecs[i].exp_lat);
    end
    check("store_word byte0", ram[14'h100], 8'hEF);
    check("store_word byte1", ram[14'h101], 8'hBE);
    check("store_word byte2", ram[14'h102], 8'hAD);
    check("store_word byte3", ram[14'h103], 8'hDE);

    // Word store across the top of the RAM; upper address bits are ignored
    run_req(1'b1, 2'd2, 1'b0, 32'hABCD_3FFE, 32'h1122_3344, "wrap_st", rd, lat);
`ifndef LSU_MISALIGN_CHECK_EN
    check("wrap byte 3ffe", ram[14'h3FFE], 8'h44);
    check("wrap byte 3fff", ram[14'h3FFF], 8'h33);
    check("wrap byte 0000", ram[14'h0000], 8'h22);
    check("wrap byte 0001", ram[14'h0001], 8'h11);
`endif
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_3FFE, 32'h0, "wrap_ld", rd, lat);

    // Misaligned word load (error response when the trap is built in)
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, "lw_mis", rd, lat);
    run_req(1'b1, 2'd1, 1'b0, 32'h0000_0021, 32'h0000_5AA5, "sh_mis", rd, lat);

    // Reset during the third byte of a word store
    @(negedge clk);
    bus.req_we_i       = 1'b1;
    bus.req_size_i     = 2'd2;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0000_0200;
    bus.req_wdata_i    = 32'hA1B2_C3D4;
    bus.req_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_mid wren_before", ram_wren, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      check("rst_mid no_rsp", bus.rsp_valid_o, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[14'h200] = 8'hD4;
    ref_mem[14'h201] = 8'hC3;
    check("rst_mid byte0", ram[14'h200], 8'hD4);
    check("rst_mid byte1", ram[14'h201], 8'hC3);
    check("rst_mid byte2", ram[14'h202], 8'h00);
    check("rst_mid byte3", ram[14'h203], 8'h00);
    @(posedge clk);
    #1;
    check("rst_mid ready_after", bus.req_ready_o, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, "rst_mid ld", rd, lat);

    // Randomized traffic in two small windows at the bottom and top of the RAM
    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      low    = ($urandom_range(0, 1) == 1) ? (16'h3FF0 + $urandom_range(0, 15))
                                           : $urandom_range(0, 63);
      r_addr = ($urandom() & 32'hFFFF_C000) | 32'(low);
      run_req(r_we, r_size, r_uns, r_addr, $urandom(), $sformatf("rnd%0d", i), rd, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
